// File: rtl/serial_shifter32.sv
// Multi-cycle 32-bit shifter: captures a/b/aluc on accept, shifts serially, then holds c until handshaked.
// Optional SERIAL_SHIFTER_STEP4_EN: shift 4 bits per cycle while at least 4 bits remain.
module serial_shifter32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [4:0]  b,
    input  logic [1:0]  aluc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] c,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [31:0] work_r;
    logic [31:0] work_nx_s;
    logic [31:0] c_r;
    logic [31:0] c_nx_s;
    logic [4:0]  cnt_r;
    logic [4:0]  cnt_nx_s;
    logic [4:0]  cnt_dec_s;
    logic [1:0]  aluc_r;
    logic [1:0]  aluc_nx_s;
    logic [2:0]  step_s;
    logic [31:0] stepped_s;

    // aluc 2'b10 and 2'b11 both fall into the left-shift default.
    function automatic logic [31:0] shift_by(input logic [31:0] v,
                                             input logic [1:0]  op,
                                             input logic [2:0]  amt);
        logic [31:0] r;
        case (op)
            2'b00:   r = 32'($signed(v) >>> amt);
            2'b01:   r = v >> amt;
            default: r = v << amt;
        endcase
        return r;
    endfunction

    // Step size for the current SHIFT cycle and the resulting datapath values.
    always_comb begin
        step_s = 3'd1;
`ifdef SERIAL_SHIFTER_STEP4_EN
        if (cnt_r >= 5'd4) begin
            step_s = 3'd4;
        end else begin
            step_s = 3'd1;
        end
`else
        step_s = 3'd1;
`endif
        cnt_dec_s = cnt_r - {2'b00, step_s};
        stepped_s = shift_by(work_r, aluc_r, step_s);
    end

    // Next-state and next-datapath logic; everything holds by default.
    always_comb begin
        state_nx_s = state_r;
        work_nx_s  = work_r;
        cnt_nx_s   = cnt_r;
        aluc_nx_s  = aluc_r;
        c_nx_s     = c_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    aluc_nx_s = aluc;
                    work_nx_s = a;
                    cnt_nx_s  = b;
                    if (b == 5'd0) begin
                        state_nx_s = DONE;
                        c_nx_s     = a;
                    end else begin
                        state_nx_s = SHIFT;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                work_nx_s = stepped_s;
                cnt_nx_s  = cnt_dec_s;
                if (cnt_dec_s == 5'd0) begin
                    state_nx_s = DONE;
                    c_nx_s     = stepped_s;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset overrides accept and the out handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            work_r  <= 32'h0000_0000;
            cnt_r   <= 5'd0;
            aluc_r  <= 2'b00;
            c_r     <= 32'h0000_0000;
        end else begin
            state_r <= state_nx_s;
            work_r  <= work_nx_s;
            cnt_r   <= cnt_nx_s;
            aluc_r  <= aluc_nx_s;
            c_r     <= c_nx_s;
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r != IDLE);
    assign c         = c_r;

endmodule

// File: tb/tb_serial_shifter32.sv
// Randomized self-checking bench for serial_shifter32 against a result/latency reference model.
module tb_serial_shifter32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [4:0]  b;
    logic [1:0]  aluc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;
    logic        busy;

    int checks_r;
    int failures_r;

    serial_shifter32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .aluc      (aluc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            failures_r++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [4:0] n,
                                              input logic [1:0] op);
        logic [31:0] r;
        if (op == 2'b00) begin
            r = v >> n;
            if (v[31]) r = r | ~(32'hFFFF_FFFF >> n);
        end else if (op == 2'b01) begin
            r = v >> n;
        end else begin
            r = v << n;
        end
        return r;
    endfunction

    function automatic int ref_lat(input logic [4:0] n);
`ifdef SERIAL_SHIFTER_STEP4_EN
        return int'(n) / 4 + int'(n) % 4 + 1;
`else
        return int'(n) + 1;
`endif
    endfunction

    // One full transaction: accept, wait for DONE, optionally stall, then handshake.
    task automatic run_op(input logic [31:0] va, input logic [4:0] vb, input logic [1:0] vop,
                          input int hold, input bit scramble);
        logic [31:0] exp_c;
        int          n;
        bit          seen;
        exp_c = ref_shift(va, vb, vop);
        @(negedge clk);
        check_val("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        a         = va;
        b         = vb;
        aluc      = vop;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        n    = 1;
        seen = 1'b0;
        while (!seen && n <= 40) begin
            if (out_valid) begin
                seen = 1'b1;
            end else begin
                check_val("busy_inready_wait", {30'd0, busy, in_ready}, 32'd2);
                if (scramble) begin
                    a        = $urandom;
                    b        = 5'($urandom_range(0, 31));
                    aluc     = 2'($urandom_range(0, 3));
                    in_valid = 1'($urandom_range(0, 1));
                end
                n++;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        check_val("latency", 32'(n), 32'(ref_lat(vb)));
        if (seen) begin
            check_val("result", c, exp_c);
            check_val("busy_inready_done", {30'd0, busy, in_ready}, 32'd2);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_val("hold_valid", {31'd0, out_valid}, 32'd1);
                check_val("hold_c", c, exp_c);
                check_val("hold_inready", {31'd0, in_ready}, 32'd0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            check_val("after_hs_valid", {31'd0, out_valid}, 32'd0);
            check_val("after_hs_ready_busy", {30'd0, in_ready, busy}, 32'd2);
            check_val("after_hs_c_hold", c, exp_c);
        end
    endtask

    initial begin
        bit got_output;
        checks_r   = 0;
        failures_r = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = 32'h0;
        b         = 5'd0;
        aluc      = 2'b00;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("rst_c", c, 32'h0);
        check_val("rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_ready_busy", {30'd0, in_ready, busy}, 32'd2);

        run_op(32'hFFFF_FFFF, 5'd3,  2'b01, 0, 1'b0);
        run_op(32'h8000_0000, 5'd4,  2'b00, 0, 1'b0);
        run_op(32'h8000_0000, 5'd4,  2'b01, 1, 1'b0);
        run_op(32'h0000_0001, 5'd31, 2'b10, 0, 1'b0);
        run_op(32'h0000_0001, 5'd31, 2'b11, 0, 1'b0);
        run_op(32'h1234_5678, 5'd0,  2'b00, 5, 1'b0);
        run_op(32'hF0F0_1234, 5'd31, 2'b00, 2, 1'b1);

        // Reset in the 5th SHIFT cycle discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'hFFFF_FFFF;
        b        = 5'd20;
        aluc     = 2'b01;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_val("mid_shift_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("mid_rst_c", c, 32'h0);
        check_val("mid_rst_ready_busy", {30'd0, in_ready, busy}, 32'd2);
        got_output = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) got_output = 1'b1;
        end
        check_val("mid_rst_no_output", {31'd0, got_output}, 32'd0);

        // Reset in DONE beats a simultaneous out handshake.
        in_valid  = 1'b1;
        a         = 32'hCAFE_BABE;
        b         = 5'd0;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check_val("done_pre_rst_c", c, 32'hCAFE_BABE);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b0;
        check_val("done_rst_c", c, 32'h0);
        check_val("done_rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("done_rst_ready_busy", {30'd0, in_ready, busy}, 32'd2);

        for (int k = 0; k < 24; k++) begin
            run_op($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                   $urandom_range(0, 3), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
